// File: rtl/dec_timer_16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dec_timer_16_pkg
// Description : Shared constants and state encoding for the dec_timer_16 block.
// Revision    : 1.0 - initial release
// ============================================================================
package dec_timer_16_pkg;

    localparam int c_DEFAULT_WIDTH = 16;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'b00;
    localparam state_t c_ST_RUN   = 2'b01;
    localparam state_t c_ST_PAUSE = 2'b10;

endpackage : dec_timer_16_pkg
`default_nettype wire

// File: rtl/dec_timer_16_if.sv
`default_nettype none
// ============================================================================
// Module      : dec_timer_16_if
// Description : Control/data bundle between the timer and its controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface dec_timer_16_if
    import dec_timer_16_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
);

    logic             ld;
    logic             start;
    logic             stop;
    logic             auto;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             tc;

    modport master (
        output ld,
        output start,
        output stop,
        output auto,
        output D,
        input  Q,
        input  busy,
        input  tc
    );

    modport slave (
        input  ld,
        input  start,
        input  stop,
        input  auto,
        input  D,
        output Q,
        output busy,
        output tc
    );

endinterface : dec_timer_16_if
`default_nettype wire

// File: rtl/dec_timer_16_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dec_timer_16_ctrl
// Description : IDLE/RUN/PAUSE sequencer with expiry detection; emits the
//               datapath controls for decrement, reload, clear and tc.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_timer_16_ctrl
    import dec_timer_16_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_ld,
    input  wire logic i_start,
    input  wire logic i_stop,
    input  wire logic i_auto,
    input  wire logic i_d_zero,
    input  wire logic i_q_zero,
    input  wire logic i_q_one,
    output logic      o_busy,
    output logic      o_dec,
    output logic      o_reload,
    output logic      o_clear,
    output logic      o_tc_set
);

    state_t r_state;
    state_t w_next;
    logic   w_run;
    logic   w_expire;
    logic   w_eff_nz;

    assign w_run    = (r_state == c_ST_RUN);
    // A load or a stop on the Q==1 cycle pre-empts expiry.
    assign w_expire = w_run & ~i_stop & ~i_ld & i_q_one;
    assign w_eff_nz = i_ld ? ~i_d_zero : ~i_q_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_PAUSE: begin
                if (!i_stop && i_start && w_eff_nz) begin
                    w_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (i_stop) begin
                    w_next = c_ST_PAUSE;
                end else if (i_ld && i_d_zero) begin
                    w_next = c_ST_IDLE;
                end else if (w_expire && !i_auto) begin
                    w_next = c_ST_IDLE;
                end
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = w_run;
        o_dec    = w_run & ~i_stop & ~i_ld & ~i_q_zero & ~i_q_one;
        o_reload = w_expire & i_auto;
        o_clear  = w_expire & ~i_auto;
        o_tc_set = w_expire;
    end

endmodule : dec_timer_16_ctrl
`default_nettype wire

// File: rtl/dec_timer_16.sv
`default_nettype none
// ============================================================================
// Module      : dec_timer_16
// Description : Loadable down-counting interval timer with terminal-count
//               pulse and optional auto-reload.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_timer_16
    import dec_timer_16_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
)(
    input  wire logic     clk,
    input  wire logic     reset,
    dec_timer_16_if.slave bus
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_tc;

    logic w_busy;
    logic w_dec;
    logic w_reload;
    logic w_clear;
    logic w_tc_set;
    logic w_d_zero;
    logic w_q_zero;
    logic w_q_one;

    assign w_d_zero = (bus.D == '0);
    assign w_q_zero = (r_q == '0);
    assign w_q_one  = (r_q == c_ONE);

    dec_timer_16_ctrl u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .i_ld     (bus.ld),
        .i_start  (bus.start),
        .i_stop   (bus.stop),
        .i_auto   (bus.auto),
        .i_d_zero (w_d_zero),
        .i_q_zero (w_q_zero),
        .i_q_one  (w_q_one),
        .o_busy   (w_busy),
        .o_dec    (w_dec),
        .o_reload (w_reload),
        .o_clear  (w_clear),
        .o_tc_set (w_tc_set)
    );

    // Load has priority over any counting action in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (bus.ld) begin
            r_q <= bus.D;
        end else if (w_dec) begin
            r_q <= r_q - c_ONE;
        end else if (w_reload) begin
            r_q <= r_r;
        end else if (w_clear) begin
            r_q <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_r <= '0;
        end else if (bus.ld) begin
            r_r <= bus.D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_tc_set;
        end
    end

    assign bus.Q    = r_q;
    assign bus.busy = w_busy;
    assign bus.tc   = r_tc;

endmodule : dec_timer_16
`default_nettype wire

// File: tb/tb_dec_timer_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_timer_16
// Description : Self-checking bench: vector table plus modelled sequences,
//               expectations queued at drive time and checked after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_timer_16;

    typedef struct {
        logic        ld;
        logic        start;
        logic        stop;
        logic        au;
        logic [15:0] d;
        logic [15:0] q;
        logic        busy;
        logic        tc;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic        busy;
        logic        tc;
    } exp_t;

    localparam int c_M_IDLE  = 0;
    localparam int c_M_RUN   = 1;
    localparam int c_M_PAUSE = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    dec_timer_16_if #(.WIDTH(16)) bus();

    dec_timer_16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] m_q;
    logic [15:0] m_r;
    int          m_state;
    logic        m_tc;

    vec_t vt[21];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: one queued expectation per clock edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (!reset && sb.size() > 0) begin
            e = sb.pop_front();
            chk("Q",    bus.Q,           e.q);
            chk("busy", {15'd0, bus.busy}, {15'd0, e.busy});
            chk("tc",   {15'd0, bus.tc},   {15'd0, e.tc});
        end
    end

    task automatic model_reset();
        m_q = '0; m_r = '0; m_state = c_M_IDLE; m_tc = 1'b0;
    endtask

    task automatic model_step(input logic ld, input logic start, input logic stop,
                              input logic au, input logic [15:0] d);
        logic [15:0] nq;
        logic [15:0] nr;
        int          ns;
        logic [15:0] eff;
        nq  = m_q;
        nr  = m_r;
        ns  = m_state;
        eff = ld ? d : m_q;
        m_tc = 1'b0;
        if (ld) begin
            nq = d;
            nr = d;
        end
        if (m_state == c_M_RUN) begin
            if (stop) begin
                ns = c_M_PAUSE;
            end else if (ld) begin
                if (d == 16'd0) ns = c_M_IDLE;
            end else if (m_q == 16'd1) begin
                m_tc = 1'b1;
                if (au) nq = m_r;
                else begin
                    nq = 16'd0;
                    ns = c_M_IDLE;
                end
            end else if (m_q > 16'd1) begin
                nq = m_q - 16'd1;
            end
        end else if (!stop && start && eff != 16'd0) begin
            ns = c_M_RUN;
        end
        m_q = nq;
        m_r = nr;
        m_state = ns;
    endtask

    task automatic drive(input logic ld, input logic start, input logic stop,
                         input logic au, input logic [15:0] d);
        @(negedge clk);
        bus.ld = ld; bus.start = start; bus.stop = stop; bus.auto = au; bus.D = d;
        model_step(ld, start, stop, au, d);
    endtask

    task automatic step(input logic ld, input logic start, input logic stop,
                        input logic au, input logic [15:0] d);
        drive(ld, start, stop, au, d);
        sb.push_back('{m_q, (m_state == c_M_RUN), m_tc});
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int tc_cnt;

        //           ld  st  sp  au  D        Q        busy tc
        vt[0]  = '{1'b1,1'b1,1'b0,1'b0,16'h0005, 16'h0005,1'b1,1'b0};
        vt[1]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0004,1'b1,1'b0};
        vt[2]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0003,1'b1,1'b0};
        vt[3]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0002,1'b1,1'b0};
        vt[4]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0001,1'b1,1'b0};
        vt[5]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1};
        vt[6]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0};
        vt[7]  = '{1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0};
        vt[8]  = '{1'b1,1'b1,1'b0,1'b0,16'h0002, 16'h0002,1'b1,1'b0};
        vt[9]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0001,1'b1,1'b0};
        vt[10] = '{1'b0,1'b0,1'b1,1'b0,16'h0000, 16'h0001,1'b0,1'b0};
        vt[11] = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0001,1'b0,1'b0};
        vt[12] = '{1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0001,1'b1,1'b0};
        vt[13] = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b1};
        vt[14] = '{1'b1,1'b1,1'b0,1'b0,16'h0004, 16'h0004,1'b1,1'b0};
        vt[15] = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0003,1'b1,1'b0};
        vt[16] = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0002,1'b1,1'b0};
        vt[17] = '{1'b1,1'b0,1'b0,1'b0,16'h0020, 16'h0020,1'b1,1'b0};
        vt[18] = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h001F,1'b1,1'b0};
        vt[19] = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0};
        vt[20] = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0};

        bus.ld = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.auto = 1'b0; bus.D = '0;
        model_reset();
        #12;
        chk("reset_Q",    bus.Q, 16'h0000);
        chk("reset_busy", {15'd0, bus.busy}, 16'd0);
        chk("reset_tc",   {15'd0, bus.tc},   16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Vector table: one-shot, zero start, stop-at-expiry, ld in RUN.
        for (int i = 0; i < 21; i++) begin
            drive(vt[i].ld, vt[i].start, vt[i].stop, vt[i].au, vt[i].d);
            sb.push_back('{vt[i].q, vt[i].busy, vt[i].tc});
        end
        drain();

        // Auto-reload N=3 over five periods.
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0003);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);

        // Pause/resume: hold Q=6 for 10 cycles, then resume to expiry.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h000A);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        drain();
        chk("pause_Q", bus.Q, 16'h0006);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Auto-reload N=1: tc every RUN cycle.
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0001);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        drain();

        // Full-range one-shot: exactly one tc, 65535 cycles after start.
        tc_cnt = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        for (int i = 0; i < 65536; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            @(posedge clk);
            #1;
            if (bus.tc) tc_cnt++;
        end
        drain();
        chk("ffff_tc_count", tc_cnt[15:0], 16'd1);

        // Asynchronous reset mid-run.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        drain();
        reset = 1'b1;
        #1;
        chk("areset_Q",    bus.Q, 16'h0000);
        chk("areset_busy", {15'd0, bus.busy}, 16'd0);
        chk("areset_tc",   {15'd0, bus.tc},   16'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dec_timer_16
`default_nettype wire
